// File: rtl/plab5_mcore_dma_arbiter_if.sv
// plab5_mcore_dma_arbiter_if: requester-side and DMA-side signals of the DMA arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface plab5_mcore_dma_arbiter_if #(
    parameter int p_num_req    = 4,
    parameter int p_addr_nbits = 32,
    parameter int p_idx_nbits  = 2
);
    logic [p_num_req-1:0]              req_val;
    logic [p_num_req-1:0]              req_rdy;
    logic [p_num_req-1:0]              req_domain;
    logic [p_num_req*p_addr_nbits-1:0] req_src_addr;
    logic [p_num_req*p_addr_nbits-1:0] req_dest_addr;
    logic [p_num_req-1:0]              resp_ack;
    logic                              resp_err;
    logic [p_idx_nbits-1:0]            grant_id;
    logic                              busy;
    logic                              dma_val;
    logic                              dma_rdy;
    logic                              dma_domain;
    logic [p_addr_nbits-1:0]           dma_src_addr;
    logic [p_addr_nbits-1:0]           dma_dest_addr;
    logic                              dma_ack;
    logic                              dma_resp_domain;

    modport master (
        input  req_val, req_domain, req_src_addr, req_dest_addr, dma_rdy, dma_ack, dma_resp_domain,
        output req_rdy, resp_ack, resp_err, grant_id, busy, dma_val, dma_domain, dma_src_addr, dma_dest_addr
    );
    modport slave (
        output req_val, req_domain, req_src_addr, req_dest_addr, dma_rdy, dma_ack, dma_resp_domain,
        input  req_rdy, resp_ack, resp_err, grant_id, busy, dma_val, dma_domain, dma_src_addr, dma_dest_addr
    );
endinterface

// File: rtl/plab5_mcore_dma_arbiter.sv
// plab5_mcore_dma_arbiter: round-robin sharing of one DMA controller, one transfer in flight.
// Define PLAB5_MCORE_DMA_ARB_TIMEOUT_EN to abort a WAIT that never sees a matching completion.
module plab5_mcore_dma_arbiter #(
    parameter int p_num_req       = 4,
    parameter int p_addr_nbits    = 32,
    parameter int p_idx_nbits     = 2,
    parameter int p_timeout_nbits = 8
) (
    input logic                  clk,
    input logic                  reset,
    plab5_mcore_dma_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (p_idx_nbits != $clog2(p_num_req) || p_timeout_nbits < 1) begin : g_cfg_err
        $error("plab5_mcore_dma_arbiter: inconsistent parameters");
    end

    state_t                  state_q, state_d;
    logic [p_idx_nbits-1:0]  ptr_q, ptr_d, grant_q, grant_d, win, cand;
    logic [p_idx_nbits:0]    idx;
    logic                    found;
    logic                    dom_q, dom_d;
    logic [p_addr_nbits-1:0] src_q, src_d, dst_q, dst_d;
`ifdef PLAB5_MCORE_DMA_ARB_TIMEOUT_EN
    logic [p_timeout_nbits-1:0] cnt_q, cnt_d;
    logic                       err_q, err_d;
`endif

    // Scan downward so the last hit is the first valid requester at or after ptr.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = p_num_req - 1; k >= 0; k--) begin
            idx  = {1'b0, ptr_q} + (p_idx_nbits+1)'(k);
            idx  = idx >= (p_idx_nbits+1)'(p_num_req) ? idx - (p_idx_nbits+1)'(p_num_req) : idx;
            cand = idx[p_idx_nbits-1:0];
            if (bus.req_val[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        dom_d   = dom_q;
        src_d   = src_q;
        dst_d   = dst_q;
`ifdef PLAB5_MCORE_DMA_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (found) begin
                state_d = ISSUE;
                grant_d = win;
                dom_d   = bus.req_domain[win];
                src_d   = bus.req_src_addr[win*p_addr_nbits +: p_addr_nbits];
                dst_d   = bus.req_dest_addr[win*p_addr_nbits +: p_addr_nbits];
            end
            ISSUE: begin
                state_d = bus.dma_rdy ? WAIT : ISSUE;
`ifdef PLAB5_MCORE_DMA_ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
            end
            WAIT: begin
`ifdef PLAB5_MCORE_DMA_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (bus.dma_ack && bus.dma_resp_domain == dom_q) state_d = RESP;
                else if (&cnt_d) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
`else
                if (bus.dma_ack && bus.dma_resp_domain == dom_q) state_d = RESP;
`endif
            end
            default: begin
                state_d = IDLE;
                ptr_d   = grant_q == p_idx_nbits'(p_num_req - 1) ? '0 : grant_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            dom_q   <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
`ifdef PLAB5_MCORE_DMA_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            dom_q   <= dom_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
`ifdef PLAB5_MCORE_DMA_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.req_rdy       = (state_q == IDLE && found) ? p_num_req'(1) << win : '0;
    assign bus.resp_ack      = state_q == RESP ? p_num_req'(1) << grant_q : '0;
`ifdef PLAB5_MCORE_DMA_ARB_TIMEOUT_EN
    assign bus.resp_err      = state_q == RESP && err_q;
`else
    assign bus.resp_err      = 1'b0;
`endif
    assign bus.grant_id      = grant_q;
    assign bus.busy          = state_q != IDLE;
    assign bus.dma_val       = state_q == ISSUE;
    assign bus.dma_domain    = dom_q;
    assign bus.dma_src_addr  = src_q;
    assign bus.dma_dest_addr = dst_q;
endmodule
